// File: rtl/quat_pkg.sv
// Shared types and helpers for the quaternion divider datapath.
// Q8.8 component format, w/i/j/k ordering, FSM states, saturation helper.
package quat_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 8;

  typedef struct packed {
    logic signed [Q_W-1:0] w;
    logic signed [Q_W-1:0] i;
    logic signed [Q_W-1:0] j;
    logic signed [Q_W-1:0] k;
  } quat_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DIV,
    S_DONE
  } state_e;

  // Sign + magnitude to a saturated two's complement value.
  function automatic logic [Q_W-1:0] sat_q(
    input logic           neg,
    input logic           ovf,
    input logic [Q_W-1:0] mag
  );
    logic [Q_W-1:0] pmax;
    logic [Q_W-1:0] nmin;
    pmax = {1'b0, {(Q_W-1){1'b1}}};
    nmin = {1'b1, {(Q_W-1){1'b0}}};
    if (!neg) begin
      sat_q = (ovf || mag > pmax) ? pmax : mag;
    end else begin
      sat_q = (ovf || mag > nmin) ? nmin : -mag;
    end
  endfunction

endpackage

// File: rtl/quat_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: start/dividend/divisor in; busy, quotient, ovf (dividend >= divisor<<QW) out.
module quat_serial_div #(
  parameter int DW = 42,
  parameter int NW = 33,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic          busy,
  output logic [QW-1:0] quotient,
  output logic          ovf
);

  localparam int CW  = NW + QW;
  localparam int CTW = $clog2(QW);

  logic [CW-1:0]  rem_q, rem_d, rem_s;
  logic [CW-1:0]  dsh_q, dsh_d, dsh_s;
  logic [QW-1:0]  quo_q, quo_d;
  logic [CTW-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic           take;

  // The start cycle already resolves the MSB from the live operands,
  // so quotient (the next-state value) is complete in the 16th cycle.
  always_comb begin
    rem_s  = start ? CW'(dividend) : rem_q;
    dsh_s  = start ? (CW'(divisor) << (QW-1)) : dsh_q;
    take   = (rem_s >= dsh_s);
    rem_d  = take ? (rem_s - dsh_s) : rem_s;
    dsh_d  = dsh_s >> 1;
    quo_d  = start ? {{(QW-1){1'b0}}, take}
                   : {quo_q[QW-2:0], take};
    busy_d = busy_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CTW'(1);
      ovf_d  = (CW'(dividend) >= (CW'(divisor) << QW));
    end else if (busy_q) begin
      cnt_d = cnt_q + CTW'(1);
      if (cnt_q == CTW'(QW-1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (start || busy_q) begin
        rem_q <= rem_d;
        dsh_q <= dsh_d;
        quo_q <= quo_d;
      end
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_d;
  assign ovf      = ovf_q;

endmodule

// File: rtl/quat_div_seq.sv
// Sequential quaternion divider y = x * conj(b) / |b|^2, Q8.8 operands.
// Ports: in_valid/in_ready + x0..3,b0..3 in; out_valid/out_ready + y0..3, err out.
module quat_div_seq
  import quat_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] x3,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] b3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y0,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic signed [W-1:0] y3,
  output logic                err
);

  localparam int NW = 2*W + 1;
  localparam int PW = 2*W + 2;
  localparam int DW = PW + FRAC;

  state_e             state_q, state_d;
  quat_t              x_q, x_d, b_q, b_d, y_q, y_d;
  logic [NW-1:0]      n_q, n_d, n_calc;
  logic [3:0][PW-1:0] p_q, p_d, p_calc;
  logic               err_q, err_d;
  logic [6:0]         cnt_q, cnt_d;

  logic [W-1:0]  xa [4];
  logic [W-1:0]  ba [4];
  logic [PW-1:0] m  [4][4];
  logic [NW-1:0] sq [4];

  logic [1:0]    ksel;
  logic [PW-1:0] pk, pabs;
  logic [DW-1:0] div_dvd;
  logic [W-1:0]  div_quot, ysat;
  logic          div_start, div_busy, div_ovf;

  // Full-precision cross products; sign extension then modular math.
  always_comb begin
    xa = '{x_q.w, x_q.i, x_q.j, x_q.k};
    ba = '{b_q.w, b_q.i, b_q.j, b_q.k};
    for (int a = 0; a < 4; a++) begin
      for (int c = 0; c < 4; c++) begin
        m[a][c] = {{(PW-W){xa[a][W-1]}}, xa[a]}
                * {{(PW-W){ba[c][W-1]}}, ba[c]};
      end
      sq[a] = {{(NW-W){ba[a][W-1]}}, ba[a]}
            * {{(NW-W){ba[a][W-1]}}, ba[a]};
    end
    n_calc    = sq[0] + sq[1] + sq[2] + sq[3];
    p_calc[0] = m[0][0] + m[1][1] + m[2][2] + m[3][3];
    p_calc[1] = m[1][0] + m[3][2] - m[0][1] - m[2][3];
    p_calc[2] = m[1][3] + m[2][0] - m[0][2] - m[3][1];
    p_calc[3] = m[2][1] + m[3][0] - m[0][3] - m[1][2];
  end

  always_comb begin
    ksel    = cnt_q[5:4];
    pk      = p_q[ksel];
    pabs    = pk[PW-1] ? -pk : pk;
    div_dvd = {pabs, {FRAC{1'b0}}};
    ysat    = sat_q(pk[PW-1], div_ovf, div_quot);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    b_d       = b_q;
    y_d       = y_q;
    n_d       = n_q;
    p_d       = p_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = '{w: x0, i: x1, j: x2, k: x3};
          b_d     = '{w: b0, i: b1, j: b2, k: b3};
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        n_d     = n_calc;
        p_d     = p_calc;
        err_d   = (n_calc == '0);
        cnt_d   = '0;
        state_d = S_DIV;
        if (n_calc == '0) y_d = '0;
      end
      S_DIV: begin
        // cnt 0..63 run the divider, 64 is the hand-over to DONE.
        if (err_q || cnt_q[6]) begin
          state_d = S_DONE;
        end else begin
          div_start = (cnt_q[3:0] == 4'd0);
          cnt_d     = cnt_q + 7'd1;
          if (div_busy && cnt_q[3:0] == 4'hF) begin
            unique case (ksel)
              2'd0: y_d.w = ysat;
              2'd1: y_d.i = ysat;
              2'd2: y_d.j = ysat;
              2'd3: y_d.k = ysat;
            endcase
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      b_q     <= b_d;
      y_q     <= y_d;
      n_q     <= n_d;
      p_q     <= p_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  quat_serial_div #(
    .DW (DW),
    .NW (NW),
    .QW (W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (n_q),
    .busy     (div_busy),
    .quotient (div_quot),
    .ovf      (div_ovf)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign err       = err_q;
  assign y0        = y_q.w;
  assign y1        = y_q.i;
  assign y2        = y_q.j;
  assign y3        = y_q.k;

endmodule
